// File: rtl/bnn_pkg.sv
// Shared types and constants for the binary CNN inference controller.
package bnn_pkg;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    localparam int IMG_W_DEF = 28;
    localparam int IMG_H_DEF = 28;
    localparam int CW_DEF    = 4;

    localparam int L_CONV1  = 0;
    localparam int L_CONV2  = 1;
    localparam int L_FC     = 2;
    localparam int L_ARGMAX = 3;

endpackage

// File: rtl/bnn_wt_wr_reg.sv
// Registered weight-write forwarder: decodes the destination layer into a
// one-cycle one-hot strobe and flags beats aimed at a non-existent layer.
module bnn_wt_wr_reg
    import bnn_pkg::*;
#(
    parameter int N_LAYERS = 4,
    parameter int LW       = 2,
    parameter int AW       = 11,
    parameter int WDW      = 33
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                accept,
    input  logic [LW-1:0]       layer,
    input  logic [AW-1:0]       addr,
    input  logic [WDW-1:0]      data,
    input  logic                err_clr,
    output logic [N_LAYERS-1:0] wr_en,
    output logic [AW-1:0]       wr_addr,
    output logic [WDW-1:0]      wr_data,
    output logic                wt_err
);

    logic [N_LAYERS-1:0] dec;
    logic                bad_layer;

    // One-hot decode of the layer index; an out-of-range index decodes to zero.
    always_comb begin
        dec = '0;
        for (int i = 0; i < N_LAYERS; i++) begin
            dec[i] = (int'(layer) == i);
        end
        bad_layer = (int'(layer) >= N_LAYERS);
    end

    // Strobe lives for exactly one cycle after the accepted beat; the error is sticky.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= '0;
            wr_addr <= '0;
            wr_data <= '0;
            wt_err  <= 1'b0;
        end else begin
            wr_en <= accept ? dec : '0;
            if (accept) begin
                wr_addr <= addr;
                wr_data <= data;
            end
            wt_err <= (wt_err & ~err_clr) | (accept & bad_layer);
        end
    end

endmodule

// File: rtl/bnn_infer_ctrl.sv
// Frame/weight ingest and layer sequencer for the binary CNN classifier:
// loads a frame row by row, starts each compute layer in turn under a
// watchdog, and presents the final class over a valid/ready port.
module bnn_infer_ctrl
    import bnn_pkg::*;
#(
    parameter int IMG_W    = IMG_W_DEF,
    parameter int IMG_H    = IMG_H_DEF,
    parameter int N_LAYERS = 4,
    parameter int LW       = 2,
    parameter int AW       = 11,
    parameter int WDW      = 33,
    parameter int CW       = CW_DEF,
    parameter int TIMEOUT  = 65535
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   row_valid,
    output logic                   row_ready,
    input  logic [IMG_W-1:0]       row_data,
    input  logic                   row_last,
    input  logic                   wt_valid,
    output logic                   wt_ready,
    input  logic [LW-1:0]          wt_layer,
    input  logic [AW-1:0]          wt_addr,
    input  logic [WDW-1:0]         wt_data,
    output logic [N_LAYERS-1:0]    wt_wr_en,
    output logic [AW-1:0]          wt_wr_addr,
    output logic [WDW-1:0]         wt_wr_data,
    output logic [IMG_H*IMG_W-1:0] img_buf,
    output logic [N_LAYERS-1:0]    layer_start,
    input  logic [N_LAYERS-1:0]    layer_done,
    input  logic [CW-1:0]          class_in,
    output logic                   class_out_valid,
    input  logic                   class_out_ready,
    output logic [CW-1:0]          class_out,
    input  logic                   abort,
    input  logic                   err_clr,
    output logic                   frame_err,
    output logic                   wt_err,
    output logic                   timeout_err,
    output logic [15:0]            frames_done
);

    localparam int RCW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [RCW-1:0]      ROW_LAST = RCW'(IMG_H - 1);
    localparam logic [TW-1:0]       WD_LAST  = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
    localparam bit                  WD_EN    = (TIMEOUT > 0);
    localparam logic [N_LAYERS-1:0] FIRST_OH = N_LAYERS'(1);

    state_t              state;
    logic [RCW-1:0]      row_cnt;
    logic [LW-1:0]       idx;
    logic [TW-1:0]       wd_cnt;
    logic                load_rdy;

    logic [N_LAYERS-1:0] idx_oh;
    logic [N_LAYERS-1:0] next_oh;
    logic                row_acc;
    logic                row_end;
    logic                frame_evt;
    logic                last_layer;
    logic                done_hit;
    logic                wd_expire;

    assign row_ready = load_rdy;
    assign wt_ready  = load_rdy;

    // Decode of the current layer, accepted-row framing, done and watchdog events.
    always_comb begin
        idx_oh  = '0;
        next_oh = '0;
        for (int i = 0; i < N_LAYERS; i++) begin
            idx_oh[i]  = (int'(idx) == i);
            next_oh[i] = (int'(idx) + 1 == i);
        end
        row_acc    = row_valid & load_rdy & ~abort;
        row_end    = (row_cnt == ROW_LAST);
        frame_evt  = row_acc & (row_end ? ~row_last : row_last);
        last_layer = (int'(idx) == N_LAYERS - 1);
        // The start-pulse cycle itself never counts as completion.
        done_hit   = ~abort & (state == S_RUN) & ~(|layer_start) & (|(layer_done & idx_oh));
        wd_expire  = WD_EN & ~abort & (state == S_RUN) & ~done_hit & (wd_cnt == WD_LAST);
    end

    // Main sequencer: frame load, per-layer start/done stepping, result hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_LOAD;
            row_cnt         <= '0;
            idx             <= LW'(L_CONV1);
            wd_cnt          <= '0;
            load_rdy        <= 1'b0;
            layer_start     <= '0;
            class_out_valid <= 1'b0;
            class_out       <= '0;
            frames_done     <= '0;
            img_buf         <= '0;
        end else begin
            layer_start <= '0;
            if (abort) begin
                state           <= S_LOAD;
                row_cnt         <= '0;
                idx             <= LW'(L_CONV1);
                wd_cnt          <= '0;
                load_rdy        <= 1'b1;
                class_out_valid <= 1'b0;
            end else begin
                case (state)
                    S_LOAD: begin
                        load_rdy <= 1'b1;
                        if (row_acc) begin
                            for (int r = 0; r < IMG_H; r++) begin
                                if (int'(row_cnt) == r) begin
                                    img_buf[r*IMG_W +: IMG_W] <= row_data;
                                end
                            end
                            if (row_end && row_last) begin
                                row_cnt     <= '0;
                                state       <= S_RUN;
                                idx         <= LW'(L_CONV1);
                                wd_cnt      <= '0;
                                layer_start <= FIRST_OH;
                                load_rdy    <= 1'b0;
                            end else if (frame_evt) begin
                                row_cnt <= '0;
                            end else begin
                                row_cnt <= row_cnt + 1'b1;
                            end
                        end
                    end
                    S_RUN: begin
                        if (done_hit) begin
                            if (last_layer) begin
                                class_out       <= class_in;
                                class_out_valid <= 1'b1;
                                frames_done     <= frames_done + 16'd1;
                                state           <= S_OUT;
                            end else begin
                                idx         <= idx + 1'b1;
                                layer_start <= next_oh;
                                wd_cnt      <= '0;
                            end
                        end else if (wd_expire) begin
                            state    <= S_LOAD;
                            idx      <= LW'(L_CONV1);
                            load_rdy <= 1'b1;
                        end else begin
                            wd_cnt <= wd_cnt + 1'b1;
                        end
                    end
                    S_OUT: begin
                        if (class_out_ready) begin
                            class_out_valid <= 1'b0;
                            state           <= S_LOAD;
                            load_rdy        <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= S_LOAD;
                        load_rdy <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Sticky framing and watchdog errors; a new event outranks a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            frame_err   <= (frame_err & ~err_clr) | frame_evt;
            timeout_err <= (timeout_err & ~err_clr) | wd_expire;
        end
    end

    bnn_wt_wr_reg #(
        .N_LAYERS (N_LAYERS),
        .LW       (LW),
        .AW       (AW),
        .WDW      (WDW)
    ) u_wt_wr (
        .clk     (clk),
        .rst_n   (rst_n),
        .accept  (wt_valid & load_rdy),
        .layer   (wt_layer),
        .addr    (wt_addr),
        .data    (wt_data),
        .err_clr (err_clr),
        .wr_en   (wt_wr_en),
        .wr_addr (wt_wr_addr),
        .wr_data (wt_wr_data),
        .wt_err  (wt_err)
    );

endmodule

// File: tb/tb_bnn_infer_ctrl.sv
// Directed bench for bnn_infer_ctrl: frame load, layer sequencing, result
// handshake, framing/weight/watchdog errors, abort and mid-run reset.
module tb_bnn_infer_ctrl;

    localparam int H   = 28;
    localparam int W   = 28;
    localparam int NL  = 4;
    localparam int LWB = 3;
    localparam int AWB = 11;
    localparam int WD  = 33;
    localparam int CWB = 4;
    localparam int TO  = 16;

    logic             clk;
    logic             rst_n;
    logic             row_valid;
    logic             row_ready;
    logic [W-1:0]     row_data;
    logic             row_last;
    logic             wt_valid;
    logic             wt_ready;
    logic [LWB-1:0]   wt_layer;
    logic [AWB-1:0]   wt_addr;
    logic [WD-1:0]    wt_data;
    logic [NL-1:0]    wt_wr_en;
    logic [AWB-1:0]   wt_wr_addr;
    logic [WD-1:0]    wt_wr_data;
    logic [H*W-1:0]   img_buf;
    logic [NL-1:0]    layer_start;
    logic [NL-1:0]    layer_done;
    logic [CWB-1:0]   class_in;
    logic             class_out_valid;
    logic             class_out_ready;
    logic [CWB-1:0]   class_out;
    logic             abort;
    logic             err_clr;
    logic             frame_err;
    logic             wt_err;
    logic             timeout_err;
    logic [15:0]      frames_done;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [LWB-1:0] layer;
        logic [AWB-1:0] addr;
        logic [WD-1:0]  data;
        logic [NL-1:0]  en;
        logic           err;
    } wt_vec_t;

    wt_vec_t        wv [4];
    logic [H*W-1:0] diag;

    bnn_infer_ctrl #(
        .IMG_W(W), .IMG_H(H), .N_LAYERS(NL), .LW(LWB),
        .AW(AWB), .WDW(WD), .CW(CWB), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data), .row_last(row_last),
        .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_layer(wt_layer), .wt_addr(wt_addr),
        .wt_data(wt_data), .wt_wr_en(wt_wr_en), .wt_wr_addr(wt_wr_addr), .wt_wr_data(wt_wr_data),
        .img_buf(img_buf), .layer_start(layer_start), .layer_done(layer_done),
        .class_in(class_in), .class_out_valid(class_out_valid), .class_out_ready(class_out_ready),
        .class_out(class_out), .abort(abort), .err_clr(err_clr), .frame_err(frame_err),
        .wt_err(wt_err), .timeout_err(timeout_err), .frames_done(frames_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [H*W-1:0] act, input logic [H*W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Row k carries a single set bit at column k; row_last on row last_idx (-1: never).
    task automatic load_frame(input int nrows, input int last_idx);
        logic [W-1:0] rd;
        for (int k = 0; k < nrows; k++) begin
            rd        = W'(1) << k;
            row_valid = 1'b1;
            row_data  = rd;
            row_last  = (k == last_idx);
            tick();
        end
        row_valid = 1'b0;
        row_last  = 1'b0;
        row_data  = '0;
    endtask

    // Entered in the start-pulse cycle of layer i; done arrives 3 cycles later.
    task automatic do_layer(input int i, input logic [CWB-1:0] cls);
        chk($sformatf("start_l%0d", i), 32'(layer_start), 32'(1 << i));
        chk($sformatf("wt_ready_run_l%0d", i), 32'(wt_ready), 0);
        tick();
        chk($sformatf("start_len_l%0d", i), 32'(layer_start), 0);
        tick();
        tick();
        layer_done = NL'(1 << i);
        class_in   = cls;
        tick();
        layer_done = '0;
        class_in   = 4'hF;
    endtask

    initial begin
        int bad;

        wv[0] = '{layer: 3'd1, addr: 11'd1199, data: 33'h1_2345_6789, en: 4'b0010, err: 1'b0};
        wv[1] = '{layer: 3'd3, addr: 11'd5,    data: 33'h0_0000_00AB, en: 4'b1000, err: 1'b0};
        wv[2] = '{layer: 3'd5, addr: 11'd7,    data: 33'h0_DEAD_BEEF, en: 4'b0000, err: 1'b1};
        wv[3] = '{layer: 3'd0, addr: 11'd2047, data: 33'h1_FFFF_FFFF, en: 4'b0001, err: 1'b1};

        diag = '0;
        for (int k = 0; k < H; k++) diag[k*W + k] = 1'b1;

        rst_n = 1'b0; row_valid = 1'b0; row_data = '0; row_last = 1'b0;
        wt_valid = 1'b0; wt_layer = '0; wt_addr = '0; wt_data = '0;
        layer_done = '0; class_in = '0; class_out_ready = 1'b0; abort = 1'b0; err_clr = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_row_ready", 32'(row_ready), 0);
        chk("rst_layer_start", 32'(layer_start), 0);
        chk("rst_valid", 32'(class_out_valid), 0);
        chk("rst_frames", 32'(frames_done), 0);
        chk("rst_wr_en", 32'(wt_wr_en), 0);
        chk("rst_errs", 32'({frame_err, wt_err, timeout_err}), 0);
        chkw("rst_img_buf", img_buf, '0);
        rst_n = 1'b1;
        tick();
        chk("row_ready_after_rst", 32'(row_ready), 1);
        chk("wt_ready_after_rst", 32'(wt_ready), 1);

        // Frame 1: diagonal image, full layer sequence, held result
        load_frame(H, H - 1);
        chkw("img_diag", img_buf, diag);
        chk("row_ready_run", 32'(row_ready), 0);
        for (int i = 0; i < NL; i++) do_layer(i, 4'd7);
        chk("valid_set", 32'(class_out_valid), 1);
        chk("class_out", 32'(class_out), 7);
        chk("frames_done_1", 32'(frames_done), 1);
        chk("row_ready_out", 32'(row_ready), 0);
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("valid_hold", 32'(class_out_valid), 1);
            chk("class_hold", 32'(class_out), 7);
        end
        class_out_ready = 1'b1;
        tick();
        class_out_ready = 1'b0;
        chk("valid_drop", 32'(class_out_valid), 0);
        chk("row_ready_back", 32'(row_ready), 1);

        // Early row_last, then missing row_last, then a good frame
        load_frame(11, 10);
        chk("frame_err_early", 32'(frame_err), 1);
        chk("no_start_early", 32'(layer_start), 0);
        chk("row_ready_early", 32'(row_ready), 1);
        load_frame(H, -1);
        chk("no_start_nolast", 32'(layer_start), 0);
        chk("row_ready_nolast", 32'(row_ready), 1);
        load_frame(H, H - 1);
        for (int i = 0; i < NL; i++) do_layer(i, 4'd3);
        chk("class_out_2", 32'(class_out), 3);
        chk("frames_done_2", 32'(frames_done), 2);
        class_out_ready = 1'b1;
        tick();
        class_out_ready = 1'b0;
        chk("frame_err_sticky", 32'(frame_err), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("frame_err_clr", 32'(frame_err), 0);

        // Weight forwarding table
        for (int i = 0; i < 4; i++) begin
            wt_valid = 1'b1;
            wt_layer = wv[i].layer;
            wt_addr  = wv[i].addr;
            wt_data  = wv[i].data;
            tick();
            wt_valid = 1'b0;
            chk($sformatf("wt_en_%0d", i), 32'(wt_wr_en), 32'(wv[i].en));
            if (wv[i].en != '0) begin
                chk($sformatf("wt_addr_%0d", i), 32'(wt_wr_addr), 32'(wv[i].addr));
                chkw($sformatf("wt_data_%0d", i), (H*W)'(wt_wr_data), (H*W)'(wv[i].data));
            end
            chk($sformatf("wt_err_%0d", i), 32'(wt_err), 32'(wv[i].err));
            tick();
            chk($sformatf("wt_en_off_%0d", i), 32'(wt_wr_en), 0);
        end
        err_clr  = 1'b1;
        wt_valid = 1'b1;
        wt_layer = 3'd4;
        tick();
        err_clr  = 1'b0;
        wt_valid = 1'b0;
        chk("wt_err_evt_wins", 32'(wt_err), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("wt_err_clr", 32'(wt_err), 0);

        // Watchdog: layer 1 never completes; wrong done bit and weight beats ignored
        load_frame(H, H - 1);
        do_layer(0, 4'd0);
        chk("start_l1_to", 32'(layer_start), 4'b0010);
        wt_valid   = 1'b1;
        wt_layer   = 3'd0;
        layer_done = 4'b0100;
        bad = 0;
        for (int j = 1; j <= 15; j++) begin
            tick();
            if (wt_wr_en != '0 || layer_start != '0 || class_out_valid) bad++;
            if (j == 14) wt_valid = 1'b0;
        end
        chk("timeout_not_yet", 32'(timeout_err), 0);
        chk("row_ready_wd_run", 32'(row_ready), 0);
        tick();
        chk("timeout_set", 32'(timeout_err), 1);
        chk("row_ready_after_to", 32'(row_ready), 1);
        chk("no_valid_after_to", 32'(class_out_valid), 0);
        chk("wd_window_quiet", 32'(bad), 0);
        chk("frames_after_to", 32'(frames_done), 2);
        layer_done = '0;

        // Abort during layer 2
        load_frame(H, H - 1);
        do_layer(0, 4'd0);
        do_layer(1, 4'd0);
        chk("start_l2_ab", 32'(layer_start), 4'b0100);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_row_ready", 32'(row_ready), 1);
        chk("abort_no_start", 32'(layer_start), 0);
        layer_done = 4'b0100;
        bad = 0;
        for (int j = 0; j < 3; j++) begin
            tick();
            if (layer_start != '0 || class_out_valid) bad++;
            layer_done = 4'b1000;
        end
        layer_done = '0;
        chk("abort_done_ignored", 32'(bad), 0);
        chk("abort_frames", 32'(frames_done), 2);
        chkw("abort_img_kept", img_buf, diag);
        chk("abort_err_kept", 32'(timeout_err), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("timeout_clr", 32'(timeout_err), 0);

        // Asynchronous reset while holding a result
        load_frame(H, H - 1);
        for (int i = 0; i < NL; i++) do_layer(i, 4'd9);
        chk("frames_done_3", 32'(frames_done), 3);
        chk("valid_before_rst", 32'(class_out_valid), 1);
        rst_n = 1'b0;
        #2;
        chk("arst_valid", 32'(class_out_valid), 0);
        chk("arst_class", 32'(class_out), 0);
        chk("arst_frames", 32'(frames_done), 0);
        chk("arst_row_ready", 32'(row_ready), 0);
        chkw("arst_img", img_buf, '0);
        bad = 0;
        for (int j = 0; j < 3; j++) begin
            tick();
            if (layer_start != '0) bad++;
        end
        rst_n = 1'b1;
        tick();
        if (layer_start != '0) bad++;
        chk("arst_no_start", 32'(bad), 0);
        chk("arst_row_ready_back", 32'(row_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
